// File: rtl/maze_pkg.sv
// Shared types, coordinates, direction codes and FSM encoding for the maze explorer.
package maze_pkg;

  localparam int MAZE_DIM    = 16;
  localparam int STACK_DEPTH = 256;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } coord_t;

  localparam coord_t START_POS = '{x: 4'd0, y: 4'd0};
  localparam coord_t GOAL_POS  = '{x: 4'(MAZE_DIM - 1), y: 4'(MAZE_DIM - 1)};

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_DOWN  = 2'b11
  } dir_e;

  typedef enum logic [3:0] {
    IDLE, MARK, PICK, READ, EVAL, PUSH, POP, DONE, FAIL, REPLAY
  } state_e;

  typedef struct packed {
    logic   ok;
    coord_t pos;
  } nbr_t;

  // Neighbour of c in direction d; ok is low when it would leave the grid.
  function automatic nbr_t step(coord_t c, dir_e d);
    nbr_t n;
    n.ok  = 1'b1;
    n.pos = c;
    case (d)
      DIR_UP:    if (c.y == 4'd0) n.ok = 1'b0; else n.pos.y = c.y - 4'd1;
      DIR_RIGHT: if (c.x == 4'(MAZE_DIM - 1)) n.ok = 1'b0; else n.pos.x = c.x + 4'd1;
      DIR_LEFT:  if (c.x == 4'd0) n.ok = 1'b0; else n.pos.x = c.x - 4'd1;
      DIR_DOWN:  if (c.y == 4'(MAZE_DIM - 1)) n.ok = 1'b0; else n.pos.y = c.y + 4'd1;
      default:   n.ok = 1'b0;
    endcase
    return n;
  endfunction

  // Undo a move taken in direction d; always in range because the move was legal.
  function automatic coord_t retreat(coord_t c, dir_e d);
    coord_t r;
    r = c;
    case (d)
      DIR_UP:    r.y = c.y + 4'd1;
      DIR_RIGHT: r.x = c.x - 4'd1;
      DIR_LEFT:  r.x = c.x + 4'd1;
      DIR_DOWN:  r.y = c.y - 4'd1;
      default:   r = c;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/maze_explorer_if.sv
// Maze memory bus: explorer drives address/strobes, memory returns the cell value.
interface maze_explorer_if;
  logic       rd;
  logic       wr;
  logic       data_in;
  logic       mem_data;
  logic [3:0] x_pos;
  logic [3:0] y_pos;

  modport master (output rd, wr, x_pos, y_pos, data_in, input mem_data);
  modport slave  (input rd, wr, x_pos, y_pos, data_in, output mem_data);
endinterface

// File: rtl/path_stack.sv
// 256x2 direction stack for the DFS path; the indexed read port exists only with MAZE_REPLAY_EN.
module path_stack
  import maze_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  dir_e       push_dir,
  output dir_e       top_dir,
  output logic [8:0] count
`ifdef MAZE_REPLAY_EN
  ,
  input  logic [7:0] rd_idx,
  output dir_e       rd_dir
`endif
);

  dir_e mem [STACK_DEPTH];

  // NOTE: the storage array is not reset; count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[count[7:0]] <= push_dir;
  end

  always_ff @(posedge clk) begin
    if (!rst)      count <= '0;
    else if (push) count <= count + 9'd1;
    else if (pop)  count <= count - 9'd1;
  end

  assign top_dir = mem[count[7:0] - 8'd1];

`ifdef MAZE_REPLAY_EN
  assign rd_dir = mem[rd_idx];
`endif

endmodule

// File: rtl/maze_explorer.sv
// Depth-first maze solver from (0,0) to (15,15) over an external 16x16 bit map.
// Path replay after success is built only when MAZE_REPLAY_EN is defined.
module maze_explorer
  import maze_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  run,
  maze_explorer_if.master       bus,
  output logic                  done,
  output logic                  fail,
  output logic [1:0]            move,
  output logic                  move_valid,
  output logic                  replay_done
);

  state_e     state, state_n;
  coord_t     cur, cur_n;
  dir_e       dir, dir_n;
  logic       origin, origin_n;
  logic       push, pop;
  dir_e       top_dir;
  logic [8:0] count;
  nbr_t       nbr;
  coord_t     addr;
  logic       rd_o, wr_o;

`ifdef MAZE_REPLAY_EN
  logic [8:0] idx, idx_n;
  dir_e       rd_dir;
`else
  logic       unused_run;
  assign unused_run = run;
`endif

  path_stack u_stack (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .push_dir (dir),
    .top_dir  (top_dir),
    .count    (count)
`ifdef MAZE_REPLAY_EN
    ,
    .rd_idx   (idx[7:0]),
    .rd_dir   (rd_dir)
`endif
  );

  assign nbr = step(cur, dir);

  // NOTE: state registers use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      cur    <= START_POS;
      dir    <= DIR_UP;
      origin <= 1'b0;
`ifdef MAZE_REPLAY_EN
      idx    <= '0;
`endif
    end else begin
      state  <= state_n;
      cur    <= cur_n;
      dir    <= dir_n;
      origin <= origin_n;
`ifdef MAZE_REPLAY_EN
      idx    <= idx_n;
`endif
    end
  end

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    state_n     = state;
    cur_n       = cur;
    dir_n       = dir;
    origin_n    = origin;
    push        = 1'b0;
    pop         = 1'b0;
    rd_o        = 1'b0;
    wr_o        = 1'b0;
    addr        = cur;
    done        = 1'b0;
    fail        = 1'b0;
    move        = 2'b00;
    move_valid  = 1'b0;
    replay_done = 1'b0;
`ifdef MAZE_REPLAY_EN
    idx_n       = idx;
`endif
    case (state)
      IDLE: if (start) begin
        state_n  = READ;
        cur_n    = START_POS;
        dir_n    = DIR_UP;
        origin_n = 1'b1;
      end
      READ: begin
        // The origin check reads cur itself; every other read probes the neighbour.
        rd_o    = 1'b1;
        if (!origin) addr = nbr.pos;
        state_n = EVAL;
      end
      EVAL: begin
        if (origin) begin
          origin_n = 1'b0;
          state_n  = bus.mem_data ? FAIL : MARK;
        end else if (!bus.mem_data) begin
          state_n = PUSH;
        end else if (dir == DIR_DOWN) begin
          state_n = POP;
        end else begin
          dir_n   = dir_e'(dir + 2'd1);
          state_n = PICK;
        end
      end
      PICK: begin
        if (nbr.ok)                state_n = READ;
        else if (dir == DIR_DOWN)  state_n = POP;
        else                       dir_n   = dir_e'(dir + 2'd1);
      end
      PUSH: begin
        push    = 1'b1;
        cur_n   = nbr.pos;
        state_n = MARK;
      end
      MARK: begin
        wr_o = 1'b1;
        if (cur == GOAL_POS) begin
          state_n = DONE;
        end else begin
          dir_n   = DIR_UP;
          state_n = PICK;
        end
      end
      POP: begin
        if (count == 9'd0) begin
          state_n = FAIL;
        end else begin
          pop     = 1'b1;
          cur_n   = retreat(cur, top_dir);
          dir_n   = dir_e'(top_dir + 2'd1);
          state_n = (top_dir == DIR_DOWN) ? POP : PICK;
        end
      end
      DONE: begin
        done = 1'b1;
`ifdef MAZE_REPLAY_EN
        if (run) begin
          idx_n   = '0;
          state_n = REPLAY;
        end
`endif
      end
      FAIL: fail = 1'b1;
`ifdef MAZE_REPLAY_EN
      REPLAY: begin
        done = 1'b1;
        if (idx == count) begin
          replay_done = 1'b1;
          state_n     = DONE;
        end else begin
          move       = rd_dir;
          move_valid = 1'b1;
          idx_n      = idx + 9'd1;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  assign bus.rd      = rd_o;
  assign bus.wr      = wr_o;
  assign bus.data_in = wr_o;
  assign bus.x_pos   = addr.x;
  assign bus.y_pos   = addr.y;

endmodule

// File: tb/tb_maze_explorer.sv
// Self-checking bench: behavioural maze memory plus a frame-stack DFS reference model.
module tb_maze_explorer;

  localparam int BUDGET = 12000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       run = 1'b0;
  logic       done, fail, move_valid, replay_done;
  logic [1:0] move;

  maze_explorer_if bus ();

  maze_explorer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .run         (run),
    .bus         (bus),
    .done        (done),
    .fail        (fail),
    .move        (move),
    .move_valid  (move_valid),
    .replay_done (replay_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  bit         walls [16][16];
  bit         seen  [16][16];
  logic       maze  [16][16];
  logic       load = 1'b0;
  logic [7:0] exp_order [$];
  logic [7:0] got_wr    [$];
  logic [1:0] exp_path  [$];
  logic [1:0] moves     [$];
  bit         exp_done;
  int         wcnt [16][16];
  int         n_rd, n_wr, n_both, n_bad_data, n_rdone;

  // Maze memory: registered read, write-through marks, bulk load from walls.
  always @(posedge clk) begin
    if (load) begin
      for (int y = 0; y < 16; y++)
        for (int x = 0; x < 16; x++)
          maze[y][x] <= walls[y][x];
    end else begin
      if (bus.wr) maze[bus.y_pos][bus.x_pos] <= bus.data_in;
      if (bus.rd) bus.mem_data <= maze[bus.y_pos][bus.x_pos];
    end
  end

  always @(negedge clk) begin
    if (load) begin
      n_rd = 0; n_wr = 0; n_both = 0; n_bad_data = 0; n_rdone = 0;
      got_wr.delete();
      moves.delete();
      for (int y = 0; y < 16; y++)
        for (int x = 0; x < 16; x++)
          wcnt[y][x] = 0;
    end else begin
      if (bus.rd) n_rd++;
      if (bus.wr) begin
        n_wr++;
        wcnt[bus.y_pos][bus.x_pos]++;
        got_wr.push_back({bus.y_pos, bus.x_pos});
        if (bus.data_in !== 1'b1) n_bad_data++;
      end
      if (bus.rd && bus.wr) n_both++;
      if (move_valid) moves.push_back(move);
      if (replay_done) n_rdone++;
    end
  end

  // Reference: DFS over frames (cell, next direction to try); the path is one entry per non-root frame.
  function automatic void model_search();
    int fx[$], fy[$], fd[$];
    int top, x, y, d, nx, ny;
    exp_order.delete();
    exp_path.delete();
    exp_done = 1'b0;
    for (int yy = 0; yy < 16; yy++)
      for (int xx = 0; xx < 16; xx++)
        seen[yy][xx] = walls[yy][xx];
    if (walls[0][0]) return;
    seen[0][0] = 1'b1;
    exp_order.push_back(8'h00);
    fx.push_back(0); fy.push_back(0); fd.push_back(0);
    while (fx.size() != 0) begin
      top = fx.size() - 1;
      x = fx[top];
      y = fy[top];
      if (x == 15 && y == 15) begin
        exp_done = 1'b1;
        break;
      end
      if (fd[top] == 4) begin
        void'(fx.pop_back()); void'(fy.pop_back()); void'(fd.pop_back());
        if (exp_path.size() != 0) void'(exp_path.pop_back());
        continue;
      end
      d = fd[top];
      fd[top] = d + 1;
      nx = x + ((d == 1) ? 1 : (d == 2) ? -1 : 0);
      ny = y + ((d == 3) ? 1 : (d == 0) ? -1 : 0);
      if (nx >= 0 && nx < 16 && ny >= 0 && ny < 16 && !seen[ny][nx]) begin
        seen[ny][nx] = 1'b1;
        exp_order.push_back(8'((ny << 4) | nx));
        exp_path.push_back(2'(d));
        fx.push_back(nx); fy.push_back(ny); fd.push_back(0);
      end
    end
  endfunction

  function automatic int order_diff();
    int n;
    n = (got_wr.size() < exp_order.size()) ? got_wr.size() : exp_order.size();
    for (int i = 0; i < n; i++)
      if (got_wr[i] !== exp_order[i]) return i;
    if (got_wr.size() != exp_order.size()) return n;
    return -1;
  endfunction

  function automatic int path_diff();
    int n;
    n = (moves.size() < exp_path.size()) ? moves.size() : exp_path.size();
    for (int i = 0; i < n; i++)
      if (moves[i] !== exp_path[i]) return i;
    if (moves.size() != exp_path.size()) return n;
    return -1;
  endfunction

  function automatic int max_wcnt();
    int m;
    m = 0;
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        if (wcnt[y][x] > m) m = wcnt[y][x];
    return m;
  endfunction

  function automatic logic [16:0] outs();
    return {bus.rd, bus.wr, bus.data_in, bus.x_pos, bus.y_pos,
            done, fail, move, move_valid, replay_done};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic load_map();
    load = 1'b1;
    tick();
    load = 1'b0;
    model_search();
  endtask

  task automatic clear_walls();
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        walls[y][x] = 1'b0;
  endtask

  task automatic run_search(input string tag, input bit with_run);
    int cyc;
    start = 1'b1;
    run   = with_run;
    tick();
    start = 1'b0;
    run   = 1'b0;
    cyc   = 1;
    while (!(done || fail) && cyc < BUDGET) begin
      tick();
      cyc++;
    end
    check({tag, "_terminated"}, 32'(done | fail), 32'd1);
  endtask

  task automatic check_search(input string tag);
    check({tag, "_done"}, 32'(done), 32'(exp_done));
    check({tag, "_fail"}, 32'(fail), 32'(!exp_done));
    check({tag, "_writes"}, n_wr, exp_order.size());
    check({tag, "_wr_order"}, order_diff(), -1);
    check({tag, "_max_wr_per_cell"}, max_wcnt(), (exp_order.size() > 0) ? 1 : 0);
    check({tag, "_rd_wr_excl"}, n_both, 0);
    check({tag, "_data_in"}, n_bad_data, 0);
  endtask

  task automatic check_replay(input string tag);
`ifdef MAZE_REPLAY_EN
    int cyc;
    run = 1'b1;
    tick();
    run = 1'b0;
    cyc = 0;
    while (n_rdone == 0 && cyc < 600) begin
      tick();
      cyc++;
    end
    tick();
    check({tag, "_replay_done_pulses"}, n_rdone, 1);
    check({tag, "_replay_len"}, moves.size(), exp_path.size());
    check({tag, "_replay_path"}, path_diff(), -1);
    check({tag, "_done_after_replay"}, 32'(done), 32'd1);
`else
    run = 1'b1;
    tick();
    run = 1'b0;
    repeat (40) tick();
    check({tag, "_no_moves"}, moves.size(), 0);
    check({tag, "_no_replay_done"}, n_rdone, 0);
    check({tag, "_done_held"}, 32'(done), 32'd1);
`endif
  endtask

  initial begin
    int rd0;

    // Reset state
    clear_walls();
    do_reset();
    check("reset_outputs", 32'(outs()), 32'd0);

    // run in IDLE is ignored
    load_map();
    run = 1'b1;
    tick();
    run = 1'b0;
    repeat (6) tick();
    check("idle_run_moves", moves.size(), 0);
    check("idle_run_reads", n_rd, 0);
    check("idle_run_done", 32'(done), 32'd0);

    // Open map, start and run together from IDLE: only start counts
    run_search("open", 1'b1);
    check_search("open");
    check("open_run_ignored", moves.size(), 0);
    rd0 = n_rd;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    check("done_ignores_start", n_rd - rd0, 0);
    check("done_level_held", 32'(done), 32'd1);
    check_replay("open");

    // Start cell blocked
    clear_walls();
    walls[0][0] = 1'b1;
    do_reset();
    load_map();
    run_search("origin_wall", 1'b0);
    check_search("origin_wall");
    check("origin_wall_no_wr", n_wr, 0);

    // Boxed in at the origin: fail after popping an empty stack
    clear_walls();
    walls[0][1] = 1'b1;
    walls[1][0] = 1'b1;
    do_reset();
    load_map();
    run_search("boxed", 1'b0);
    check_search("boxed");
    check("boxed_single_wr_addr", (got_wr.size() == 1) ? 32'(got_wr[0]) : 32'hFFFF, 32'h00);

    // Dead-end corridor along row 0 forces a three-deep backtrack
    clear_walls();
    walls[0][4] = 1'b1;
    walls[1][1] = 1'b1;
    walls[1][2] = 1'b1;
    walls[1][3] = 1'b1;
    do_reset();
    load_map();
    run_search("corridor", 1'b0);
    check_search("corridor");
    check_replay("corridor");

    // Random maps against the reference
    for (int r = 0; r < 6; r++) begin
      for (int y = 0; y < 16; y++)
        for (int x = 0; x < 16; x++)
          walls[y][x] = ($urandom_range(0, 99) < 30);
      walls[0][0] = 1'b0;
      if (r < 3) walls[15][15] = 1'b0;
      do_reset();
      load_map();
      run_search($sformatf("rand%0d", r), 1'b0);
      check_search($sformatf("rand%0d", r));
      if (exp_done) check_replay($sformatf("rand%0d", r));
    end

    // Reset in the middle of a search, then a fresh search
    clear_walls();
    do_reset();
    load_map();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (39) tick();
    check("midreset_busy", 32'(done | fail), 32'd0);
    rst = 1'b0;
    tick();
    check("midreset_outputs", 32'(outs()), 32'd0);
    rst = 1'b1;
    tick();
    load_map();
    run_search("after_reset", 1'b0);
    check_search("after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
